// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared constants and state encoding for the layer sequencer
// Purpose: state enum, bus widths and memory map base addresses used by the
//          inference engines and the sequencer.
// Ports:   none (package)
package nn_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 16;

  localparam int W1_BASE     = 800;
  localparam int IMG_BASE    = 300000;
  localparam int LAYER1_BASE = 400000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    RUN     = 3'd2,
    RELEASE = 3'd3,
    FINISH  = 3'd4,
    DRAIN   = 3'd5
  } nn_state_e;

endpackage

// File: rtl/avmm_mux.sv
// rtl/avmm_mux.sv - grant mux for the shared SDRAM master plus outstanding-read tracker
// Purpose: routes the granted engine's Avalon-MM request to the shared master with
//          no added latency, and tracks the single outstanding read.
// Ports:   clk, reset_n               - clock, async active-low reset
//          i_grant_valid, i_layer_idx - grant enable and granted engine index
//          i_lyr_*                    - packed per-engine request fields
//          i_waitrequest, i_readdatavalid - from SDRAM
//          o_lyr_waitrequest, o_lyr_readdatavalid - per-engine responses
//          o_address, o_read_n, o_write_n, o_writedata - shared master request
//          o_pending                  - a read has been accepted and not yet returned
module avmm_mux #(
  parameter int NUM_LAYERS = 3,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 16,
  parameter int IDX_W      = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_grant_valid,
  input  logic [IDX_W-1:0]             i_layer_idx,
  input  logic [NUM_LAYERS*ADDR_W-1:0] i_lyr_address,
  input  logic [NUM_LAYERS-1:0]        i_lyr_read_n,
  input  logic [NUM_LAYERS-1:0]        i_lyr_write_n,
  input  logic [NUM_LAYERS*DATA_W-1:0] i_lyr_writedata,
  input  logic                         i_waitrequest,
  input  logic                         i_readdatavalid,
  output logic [NUM_LAYERS-1:0]        o_lyr_waitrequest,
  output logic [NUM_LAYERS-1:0]        o_lyr_readdatavalid,
  output logic [ADDR_W-1:0]            o_address,
  output logic                         o_read_n,
  output logic                         o_write_n,
  output logic [DATA_W-1:0]            o_writedata,
  output logic                         o_pending
);

  logic r_pending;

  always_comb begin
    o_address           = '0;
    o_read_n            = 1'b1;
    o_write_n           = 1'b1;
    o_writedata         = '0;
    o_lyr_waitrequest   = '1;
    o_lyr_readdatavalid = '0;
    if (i_grant_valid) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (i_layer_idx == IDX_W'(i)) begin
          o_address              = i_lyr_address[i*ADDR_W +: ADDR_W];
          o_read_n               = i_lyr_read_n[i];
          o_write_n              = i_lyr_write_n[i];
          o_writedata            = i_lyr_writedata[i*DATA_W +: DATA_W];
          o_lyr_waitrequest[i]   = i_waitrequest;
          o_lyr_readdatavalid[i] = i_readdatavalid;
        end
      end
    end
  end

  // Accept has priority over return so back-to-back read/return keeps the count at one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 1'b0;
    end else if (!o_read_n && !i_waitrequest) begin
      r_pending <= 1'b1;
    end else if (i_readdatavalid) begin
      r_pending <= 1'b0;
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/nn_layer_sched.sv
// rtl/nn_layer_sched.sv - sequences the inference engines and owns the shared SDRAM master
// Purpose: runs engines 0..NUM_LAYERS-1 in order via ready/done, grants the SDRAM
//          master to the active engine only, and reports status to HPS and hex LEDs.
// Ports:   clk, reset_n                - clock, async active-low reset
//          start, abort                - HPS run request (edge) and abort (level)
//          busy, run_done, err         - run status
//          layer_ready, layer_done     - per-engine handshake
//          lyr_*                       - per-engine Avalon-MM slave side
//          address..readdata           - shared Avalon-MM master to SDRAM
//          toHexLed                    - {16'h0, err, layer_idx, 4'h0, state}
module nn_layer_sched #(
  parameter int          NUM_LAYERS = 3,
  parameter int          ADDR_W     = nn_pkg::ADDR_W,
  parameter int          DATA_W     = nn_pkg::DATA_W,
  parameter logic [23:0] TIMEOUT    = 24'hFFFFFF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         abort,
  output logic                         busy,
  output logic                         run_done,
  output logic                         err,
  output logic [NUM_LAYERS-1:0]        layer_ready,
  input  logic [NUM_LAYERS-1:0]        layer_done,
  input  logic [NUM_LAYERS*ADDR_W-1:0] lyr_address,
  input  logic [NUM_LAYERS-1:0]        lyr_read_n,
  input  logic [NUM_LAYERS-1:0]        lyr_write_n,
  input  logic [NUM_LAYERS*DATA_W-1:0] lyr_writedata,
  output logic [NUM_LAYERS-1:0]        lyr_waitrequest,
  output logic [NUM_LAYERS-1:0]        lyr_readdatavalid,
  output logic [DATA_W-1:0]            lyr_readdata,
  output logic [ADDR_W-1:0]            address,
  output logic                         read_n,
  output logic                         write_n,
  output logic [DATA_W-1:0]            writedata,
  output logic                         chipselect,
  output logic [1:0]                   byteenable,
  input  logic                         waitrequest,
  input  logic                         readdatavalid,
  input  logic [DATA_W-1:0]            readdata,
  output logic [31:0]                  toHexLed
);
  import nn_pkg::*;

  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  nn_state_e             r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_layer_idx, w_idx_nxt;
  logic [NUM_LAYERS-1:0] r_layer_ready, w_ready_nxt;
  logic                  r_grant_valid, w_grant_nxt;
  logic [23:0]           r_timer, w_timer_nxt;
  logic                  r_err, w_err_nxt;
  logic                  r_run_done, w_run_done_nxt;
  logic                  r_start_d;
  logic                  w_start_rise;
  logic                  w_pending;

  assign w_start_rise = start & ~r_start_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_layer_idx   <= '0;
      r_layer_ready <= '0;
      r_grant_valid <= 1'b0;
      r_timer       <= '0;
      r_err         <= 1'b0;
      r_run_done    <= 1'b0;
      r_start_d     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_layer_idx   <= w_idx_nxt;
      r_layer_ready <= w_ready_nxt;
      r_grant_valid <= w_grant_nxt;
      r_timer       <= w_timer_nxt;
      r_err         <= w_err_nxt;
      r_run_done    <= w_run_done_nxt;
      r_start_d     <= start;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_layer_idx;
    w_ready_nxt    = r_layer_ready;
    w_grant_nxt    = r_grant_valid;
    w_timer_nxt    = r_timer;
    w_err_nxt      = r_err;
    w_run_done_nxt = r_run_done;
    unique case (r_state)
      IDLE: begin
        if (w_start_rise) begin
          w_err_nxt   = 1'b0;
          w_idx_nxt   = '0;
          w_state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        w_ready_nxt              = '0;
        w_ready_nxt[r_layer_idx] = 1'b1;
        w_grant_nxt              = 1'b1;
        w_timer_nxt              = '0;
        w_state_nxt              = RUN;
      end
      RUN: begin
        w_timer_nxt = r_timer + 24'd1;
        // done outranks timeout, which outranks abort
        if (layer_done[r_layer_idx]) begin
          w_ready_nxt = '0;
          w_grant_nxt = 1'b0;
          w_state_nxt = RELEASE;
        end else if (r_timer == TIMEOUT) begin
          w_err_nxt   = 1'b1;
          w_ready_nxt = '0;
          w_state_nxt = DRAIN;
        end else if (abort) begin
          w_ready_nxt = '0;
          w_state_nxt = DRAIN;
        end
      end
      RELEASE: begin
        if (!layer_done[r_layer_idx]) begin
          if (r_layer_idx == IDX_W'(NUM_LAYERS - 1)) begin
            w_run_done_nxt = 1'b1;
            w_state_nxt    = FINISH;
          end else begin
            w_idx_nxt   = r_layer_idx + 1'b1;
            w_state_nxt = LAUNCH;
          end
        end
      end
      FINISH: begin
        if (!start) begin
          w_run_done_nxt = 1'b0;
          w_state_nxt    = IDLE;
        end
      end
      DRAIN: begin
        // keep the grant so an in-flight read returns to its engine
        if (!w_pending) begin
          w_grant_nxt = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  avmm_mux #(
    .NUM_LAYERS(NUM_LAYERS),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .IDX_W     (IDX_W)
  ) u_avmm_mux (
    .clk                (clk),
    .reset_n            (reset_n),
    .i_grant_valid      (r_grant_valid),
    .i_layer_idx        (r_layer_idx),
    .i_lyr_address      (lyr_address),
    .i_lyr_read_n       (lyr_read_n),
    .i_lyr_write_n      (lyr_write_n),
    .i_lyr_writedata    (lyr_writedata),
    .i_waitrequest      (waitrequest),
    .i_readdatavalid    (readdatavalid),
    .o_lyr_waitrequest  (lyr_waitrequest),
    .o_lyr_readdatavalid(lyr_readdatavalid),
    .o_address          (address),
    .o_read_n           (read_n),
    .o_write_n          (write_n),
    .o_writedata        (writedata),
    .o_pending          (w_pending)
  );

  assign busy         = (r_state == LAUNCH) || (r_state == RUN) ||
                        (r_state == RELEASE) || (r_state == DRAIN);
  assign run_done     = r_run_done;
  assign err          = r_err;
  assign layer_ready  = r_layer_ready;
  assign lyr_readdata = readdata;
  assign chipselect   = 1'b1;
  assign byteenable   = 2'b11;
  assign toHexLed     = {16'h0, 3'b000, r_err, 4'(r_layer_idx), 4'h0, 1'b0, r_state};

endmodule

// File: tb/tb_nn_layer_sched.sv
// tb/tb_nn_layer_sched.sv - self-checking bench for the layer sequencer
module tb_nn_layer_sched;
  import nn_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, abort;
  logic        busy, run_done, err;
  logic [2:0]  layer_ready, layer_done;
  logic [95:0] lyr_address;
  logic [2:0]  lyr_read_n, lyr_write_n;
  logic [47:0] lyr_writedata;
  logic [2:0]  lyr_waitrequest, lyr_readdatavalid;
  logic [15:0] lyr_readdata;
  logic [31:0] address;
  logic        read_n, write_n;
  logic [15:0] writedata;
  logic        chipselect;
  logic [1:0]  byteenable;
  logic        waitrequest, readdatavalid;
  logic [15:0] readdata;
  logic [31:0] toHexLed;

  int pass_cnt = 0;
  int total_cnt = 0;

  nn_layer_sched #(.NUM_LAYERS(3), .ADDR_W(32), .DATA_W(16), .TIMEOUT(24'd100)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .busy(busy), .run_done(run_done), .err(err),
    .layer_ready(layer_ready), .layer_done(layer_done),
    .lyr_address(lyr_address), .lyr_read_n(lyr_read_n), .lyr_write_n(lyr_write_n),
    .lyr_writedata(lyr_writedata), .lyr_waitrequest(lyr_waitrequest),
    .lyr_readdatavalid(lyr_readdatavalid), .lyr_readdata(lyr_readdata),
    .address(address), .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .chipselect(chipselect), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdatavalid(readdatavalid), .readdata(readdata),
    .toHexLed(toHexLed)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Engine models: done rises once ready has been held for eng_dly cycles.
  int eng_cnt[3] = '{0, 0, 0};
  int eng_dly[3] = '{1000, 1000, 1000};
  always @(posedge clk)
    for (int i = 0; i < 3; i++) eng_cnt[i] <= layer_ready[i] ? eng_cnt[i] + 1 : 0;
  always_comb begin
    layer_done = '0;
    for (int i = 0; i < 3; i++) layer_done[i] = layer_ready[i] && (eng_cnt[i] >= eng_dly[i]);
  end

  // SDRAM model with scoreboard: expectation pushed on read acceptance.
  typedef struct { logic [2:0] vec; logic [15:0] data; } sb_t;
  sb_t  sb_q[$];
  int   sb_pops = 0;
  bit   model_on = 0;
  int   mdl_dly = 0;
  int   cur_eng = 0;
  logic tb_wreq, tb_rdv;

  assign waitrequest   = model_on ? 1'b0 : tb_wreq;
  assign readdatavalid = model_on ? (mdl_dly == 1) : tb_rdv;
  assign readdata      = (model_on && mdl_dly == 1) ? 16'h1234 : 16'h0000;

  always @(posedge clk) begin
    if (model_on && !read_n && !waitrequest) begin
      mdl_dly <= 8;
      sb_q.push_back('{vec: 3'(1 << cur_eng), data: 16'h1234});
    end else if (mdl_dly > 0) begin
      mdl_dly <= mdl_dly - 1;
    end
  end

  always @(negedge clk) begin
    if (model_on && |lyr_readdatavalid) begin
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_unexpected: got rdv %b expected none", lyr_readdatavalid);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("sb_rdv_vec", 64'(lyr_readdatavalid), 64'(e.vec));
        check("sb_rdata", 64'(lyr_readdata), 64'(e.data));
        sb_pops++;
      end
    end
  end

  // Record the order of one-hot ready values.
  bit         cap_on = 0;
  logic [2:0] prev_ready = '0;
  logic [2:0] seq[$];
  always @(negedge clk) begin
    if (cap_on && layer_ready != 3'b000 && layer_ready != prev_ready) seq.push_back(layer_ready);
    prev_ready <= layer_ready;
  end

  typedef struct {
    bit act; logic [2:0] rd_n, wr_n; logic wreq, rdv;
    logic exp_rd, exp_wr; logic [31:0] exp_addr; logic [15:0] exp_wd;
    logic [2:0] exp_lwreq, exp_lrdv;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    bit started;
    logic [8:0] sv;

    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    tb_wreq = 1'b1; tb_rdv = 1'b0;
    lyr_read_n = 3'b111; lyr_write_n = 3'b111;
    lyr_address   = {32'(W1_BASE), 32'(LAYER1_BASE), 32'(IMG_BASE)};
    lyr_writedata = {16'hA002, 16'hA001, 16'hA000};

    tbl[0] = '{0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0,      16'h0000, 3'b111, 3'b000};
    tbl[1] = '{0, 3'b110, 3'b111, 1'b1, 1'b0, 1'b1, 1'b1, 32'd0,      16'h0000, 3'b111, 3'b000};
    tbl[2] = '{1, 3'b101, 3'b111, 1'b0, 1'b0, 1'b1, 1'b1, 32'd300000, 16'hA000, 3'b110, 3'b000};
    tbl[3] = '{1, 3'b110, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 32'd300000, 16'hA000, 3'b111, 3'b000};
    tbl[4] = '{1, 3'b111, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 32'd300000, 16'hA000, 3'b110, 3'b000};
    tbl[5] = '{1, 3'b111, 3'b011, 1'b0, 1'b1, 1'b1, 1'b1, 32'd300000, 16'hA000, 3'b110, 3'b001};

    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_run_done", 64'(run_done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_layer_ready", 64'(layer_ready), 64'd0);
    check("rst_read_n", 64'(read_n), 64'd1);
    check("rst_write_n", 64'(write_n), 64'd1);
    check("rst_chipselect", 64'(chipselect), 64'd1);
    check("rst_byteenable", 64'(byteenable), 64'd3);
    check("rst_hex", 64'(toHexLed), 64'd0);
    @(negedge clk); reset_n = 1'b1;

    // Mux vectors: idle rows first, then rows with engine 0 granted.
    started = 0;
    for (int r = 0; r < 6; r++) begin
      if (tbl[r].act && !started) begin
        lyr_read_n = 3'b111; lyr_write_n = 3'b111;
        @(negedge clk); start = 1'b1;
        n = 0;
        while (layer_ready !== 3'b001 && n < 20) begin @(negedge clk); n++; end
        check("vec_ready0", 64'(layer_ready), 64'd1);
        started = 1;
      end
      @(negedge clk);
      lyr_read_n = tbl[r].rd_n; lyr_write_n = tbl[r].wr_n;
      tb_wreq = tbl[r].wreq; tb_rdv = tbl[r].rdv;
      #2;
      check($sformatf("vec%0d_read_n", r), 64'(read_n), 64'(tbl[r].exp_rd));
      check($sformatf("vec%0d_write_n", r), 64'(write_n), 64'(tbl[r].exp_wr));
      check($sformatf("vec%0d_address", r), 64'(address), 64'(tbl[r].exp_addr));
      check($sformatf("vec%0d_writedata", r), 64'(writedata), 64'(tbl[r].exp_wd));
      check($sformatf("vec%0d_lyr_wreq", r), 64'(lyr_waitrequest), 64'(tbl[r].exp_lwreq));
      check($sformatf("vec%0d_lyr_rdv", r), 64'(lyr_readdatavalid), 64'(tbl[r].exp_lrdv));
    end

    // Abort with an outstanding read from engine 0.
    @(negedge clk);
    lyr_write_n = 3'b111; tb_wreq = 1'b1; tb_rdv = 1'b0;
    cur_eng = 0; model_on = 1; lyr_read_n = 3'b110;
    @(negedge clk); lyr_read_n = 3'b111; abort = 1'b1;
    @(negedge clk);
    check("abort_drain_state", 64'(toHexLed[3:0]), 64'd5);
    check("abort_busy", 64'(busy), 64'd1);
    check("abort_ready_low", 64'(layer_ready), 64'd0);
    @(negedge clk);
    check("abort_grant_held", 64'(lyr_waitrequest[0]), 64'd0);
    n = 0;
    while (toHexLed[3:0] != 4'd0 && n < 30) begin @(negedge clk); n++; end
    check("abort_idle", 64'(toHexLed[3:0]), 64'd0);
    check("abort_rdv_seen", 64'(sb_pops), 64'd1);
    check("abort_busy_low", 64'(busy), 64'd0);
    check("abort_no_err", 64'(err), 64'd0);
    check("abort_read_n", 64'(read_n), 64'd1);
    abort = 1'b0; model_on = 0; start = 1'b0;

    // Normal run, each engine done after 50 cycles.
    eng_dly[0] = 50; eng_dly[1] = 50; eng_dly[2] = 50;
    seq.delete(); cap_on = 1;
    @(negedge clk); @(negedge clk); start = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!run_done && n < 400);
    cap_on = 0;
    check("run_done", 64'(run_done), 64'd1);
    check("run_latency_window", 64'(n >= 155 && n <= 165), 64'd1);
    check("run_busy_low", 64'(busy), 64'd0);
    check("run_hex_state", 64'(toHexLed[3:0]), 64'd4);
    sv = (seq.size() == 3) ? {seq[0], seq[1], seq[2]} : 9'h1ff;
    check("run_ready_order", 64'(sv), 64'b001_010_100);
    @(negedge clk);
    check("finish_hold", 64'(run_done), 64'd1);
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    check("finish_released", 64'(run_done), 64'd0);
    check("finish_idle", 64'(toHexLed[3:0]), 64'd0);

    // Timeout on engine 0.
    eng_dly[0] = 100000;
    start = 1'b1;
    n = 0;
    while (layer_ready !== 3'b001 && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (!err && n < 300) begin @(negedge clk); n++; end
    check("timeout_cycles", 64'(n), 64'd101);
    check("timeout_ready_low", 64'(layer_ready), 64'd0);
    n = 0;
    while (toHexLed[3:0] != 4'd0 && n < 10) begin @(negedge clk); n++; end
    check("timeout_idle", 64'(toHexLed[3:0]), 64'd0);
    check("timeout_err_sticky", 64'(err), 64'd1);
    check("timeout_hex_err", 64'(toHexLed[12]), 64'd1);
    start = 1'b0;

    // Next start clears err; this run has done and timeout coinciding.
    eng_dly[0] = 100; eng_dly[1] = 5; eng_dly[2] = 5;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    check("restart_clears_err", 64'(err), 64'd0);
    @(negedge clk);
    n = 0;
    while (layer_ready !== 3'b001 && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (toHexLed[3:0] != 4'd3 && n < 300) begin @(negedge clk); n++; end
    check("tie_release_cycles", 64'(n), 64'd101);
    check("tie_err_low", 64'(err), 64'd0);
    n = 0;
    while (!run_done && n < 200) begin @(negedge clk); n++; end
    check("tie_run_done", 64'(run_done), 64'd1);
    check("tie_err_final", 64'(err), 64'd0);
    start = 1'b0;
    @(negedge clk); @(negedge clk);

    // Asynchronous reset in the middle of RUN.
    eng_dly[0] = 1000;
    start = 1'b1;
    n = 0;
    while (layer_ready !== 3'b001 && n < 20) begin @(negedge clk); n++; end
    lyr_read_n = 3'b110; tb_wreq = 1'b1;
    #1;
    check("pre_reset_read_n", 64'(read_n), 64'd0);
    #1 reset_n = 1'b0;
    #1;
    check("mid_reset_ready", 64'(layer_ready), 64'd0);
    check("mid_reset_busy", 64'(busy), 64'd0);
    check("mid_reset_err", 64'(err), 64'd0);
    check("mid_reset_read_n", 64'(read_n), 64'd1);
    check("mid_reset_address", 64'(address), 64'd0);
    @(negedge clk);
    start = 1'b0; lyr_read_n = 3'b111; reset_n = 1'b1;
    @(negedge clk); @(negedge clk);
    check("post_reset_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
